// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN accelerator input path: fetch FSM
// states, image defaults, register offsets and the OBI request/response structs.
package cnn_pkg;

    localparam int PIX_PER_WORD  = 4;
    localparam int IMG_W_DEFAULT = 28;
    localparam int IMG_H_DEFAULT = 28;

    // Accelerator register file byte offsets
    localparam logic [7:0] REG_START      = 8'h00;
    localparam logic [7:0] REG_INPUT_BASE = 8'h08;

    typedef enum logic [2:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_DRAIN,
        FETCH_DONE
    } fetch_state_e;

    // OBI address channel (32-bit data, 1-bit id)
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } obi_a_t;

    typedef struct packed {
        logic   req;
        obi_a_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } obi_r_t;

    typedef struct packed {
        logic   gnt;
        logic   rvalid;
        obi_r_t r;
    } obi_rsp_t;

    // Byte address of a 32-bit word relative to a word-aligned base; wraps mod 2^32
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [29:0] idx);
        return base + {idx, 2'b00};
    endfunction

endpackage

// File: rtl/cnn_word_unpacker.sv
// Holds one 32-bit word and presents its bytes, lowest first, on a valid/ready
// stream. last_o pulses on the handshake of the fourth byte.
module cnn_word_unpacker
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [31:0]           word_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] pixel_o,
    output logic                  last_o
);

    logic [31:0]           word_q, word_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic                  valid_q, valid_d;
    logic                  fire;
    logic [DATA_WIDTH-1:0] byte_lane [PIX_PER_WORD];

    for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
        assign byte_lane[gi] = word_q[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Load a fresh word or advance through its bytes on each handshake
    always_comb begin
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        valid_d    = valid_q;
        fire       = valid_q & ready_i;
        last_o     = fire && (byte_idx_q == 2'd3);
        if (load_i) begin
            word_d     = word_i;
            byte_idx_d = 2'd0;
            valid_d    = 1'b1;
        end else if (fire) begin
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
                valid_d = 1'b0;
            end
        end
    end

    // Word, byte pointer and valid registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q     <= '0;
            byte_idx_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            valid_q    <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign pixel_o = byte_lane[byte_idx_q];

endmodule

// File: rtl/cnn_pixel_fetcher.sv
// OBI read engine: fetches IMG_W*IMG_H 8-bit pixels as 32-bit words from
// base_addr_i and streams them to the line buffer one pixel per handshake.
// Exactly one read is ever outstanding.
module cnn_pixel_fetcher
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = IMG_W_DEFAULT,
    parameter int IMG_H      = IMG_H_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [31:0]           base_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output obi_req_t              obi_req_o,
    input  obi_rsp_t              obi_rsp_i,
    output logic [DATA_WIDTH-1:0] pixel_o,
    output logic                  pixel_valid_o,
    input  logic                  pixel_ready_i
);

    localparam int NWORDS = (IMG_W * IMG_H) / PIX_PER_WORD;
    localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NWORDS - 1);

    if (((IMG_W * IMG_H) % PIX_PER_WORD) != 0) begin : g_bad_image_size
        $error("cnn_pixel_fetcher: IMG_W*IMG_H must be a multiple of 4");
    end
    if (DATA_WIDTH != 8) begin : g_bad_data_width
        $error("cnn_pixel_fetcher: DATA_WIDTH must be 8");
    end

    fetch_state_e      state_q, state_d;
    logic [31:0]       base_q, base_d;
    logic [WIDX_W-1:0] word_idx_q, word_idx_d;
    logic              err_q, err_d;
    logic              load_word;
    logic              last_pix;
    logic              unused_bits;

    // Only the word-aligned part of the base and no response id are needed
    assign unused_bits = ^{obi_rsp_i.r.rid, base_addr_i[1:0]};

    // Next-state, address generation and OBI request drive
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        word_idx_d = word_idx_q;
        err_d      = err_q;
        load_word  = 1'b0;
        obi_req_o  = '0;
        case (state_q)
            FETCH_IDLE: begin
                if (start_i) begin
                    base_d     = {base_addr_i[31:2], 2'b00};
                    word_idx_d = '0;
                    err_d      = 1'b0;
                    state_d    = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                // All a.* fields derive from registers, so they hold until gnt
                obi_req_o.req    = 1'b1;
                obi_req_o.a.be   = 4'hF;
                obi_req_o.a.addr = word_addr(base_q, 30'(word_idx_q));
                if (obi_rsp_i.gnt) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (obi_rsp_i.rvalid) begin
                    load_word = 1'b1;
                    if (obi_rsp_i.r.err) begin
                        err_d = 1'b1;
                    end
                    state_d = FETCH_DRAIN;
                end
            end
            FETCH_DRAIN: begin
                if (last_pix) begin
                    if (word_idx_q == LAST_WORD) begin
                        state_d = FETCH_DONE;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = FETCH_REQ;
                    end
                end
            end
            FETCH_DONE: begin
                state_d = FETCH_IDLE;
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // FSM, base address, word counter and sticky error registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= FETCH_IDLE;
            base_q     <= '0;
            word_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            word_idx_q <= word_idx_d;
            err_q      <= err_d;
        end
    end

    cnn_word_unpacker #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_unpacker (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load_word),
        .word_i (obi_rsp_i.r.rdata),
        .ready_i(pixel_ready_i),
        .valid_o(pixel_valid_o),
        .pixel_o(pixel_o),
        .last_o (last_pix)
    );

    assign busy_o = (state_q != FETCH_IDLE);
    assign done_o = (state_q == FETCH_DONE);
    assign err_o  = err_q;

endmodule
